// File: rtl/apb_otp_pkg.sv
// Shared constants for the APB one-time-pad keystore: register map, CTRL/STATUS
// field positions and the controller state encoding.
package apb_otp_pkg;

    localparam logic [31:0] AddrData   = 32'h10;
    localparam logic [31:0] AddrCtrl   = 32'h11;
    localparam logic [31:0] AddrStatus = 32'h12;
    localparam logic [31:0] AddrResult = 32'h13;

    localparam int unsigned CtrlSelLsb   = 0;
    localparam int unsigned CtrlSelW     = 4;
    localparam int unsigned CtrlLockBit  = 4;
    localparam int unsigned CtrlZeroBit  = 5;
    localparam int unsigned StatDoneBit  = 2;
    localparam int unsigned StatValidLsb = 16;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2,
        StZero = 2'd3
    } otp_state_e;

endpackage

// File: rtl/otp_key_bank.sv
// Key slot storage with valid bits, single-slot clear and a one-slot-per-cycle
// zeroize sweep. A clear or sweep of a slot wins over a write to it.
module otp_key_bank
    import apb_otp_pkg::*;
#(
    parameter int unsigned WIDTH    = 128,
    parameter int unsigned NUM_KEYS = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               we_i,
    input  logic [CtrlSelW-1:0]                widx_i,
    input  logic [WIDTH-1:0]                   wdata_i,
    input  logic                               clr_i,
    input  logic [CtrlSelW-1:0]                clr_idx_i,
    input  logic                               sweep_start_i,
    input  logic                               sweep_i,
    output logic                               sweep_last_o,
    output logic [NUM_KEYS-1:0][WIDTH-1:0]     keys_o,
    output logic [NUM_KEYS-1:0]                valid_o
);

    logic [NUM_KEYS-1:0][WIDTH-1:0] key_q, key_d;
    logic [NUM_KEYS-1:0]            valid_q, valid_d;
    logic [CtrlSelW-1:0]            zcnt_q, zcnt_d;

    always_comb begin
        key_d   = key_q;
        valid_d = valid_q;
        zcnt_d  = zcnt_q;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (we_i && widx_i == CtrlSelW'(i)) begin
                key_d[i]   = wdata_i;
                valid_d[i] = 1'b1;
            end
            if ((clr_i && clr_idx_i == CtrlSelW'(i)) || (sweep_i && zcnt_q == CtrlSelW'(i))) begin
                key_d[i]   = '0;
                valid_d[i] = 1'b0;
            end
        end
        if (sweep_start_i) begin
            zcnt_d = '0;
        end else if (sweep_i) begin
            zcnt_d = zcnt_q + CtrlSelW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            key_q   <= '0;
            valid_q <= '0;
            zcnt_q  <= '0;
        end else begin
            key_q   <= key_d;
            valid_q <= valid_d;
            zcnt_q  <= zcnt_d;
        end
    end

    assign sweep_last_o = sweep_i && (zcnt_q == CtrlSelW'(NUM_KEYS - 1));
    assign keys_o       = key_q;
    assign valid_o      = valid_q;

endmodule

// File: rtl/apb_otp_keystore.sv
// APB keystore XORing a data word with a single-use key, one LANE slice per cycle.
// Define APB_OTP_PSLVERR_EN to report rejected accesses on pslverr.
module apb_otp_keystore
    import apb_otp_pkg::*;
#(
    parameter int unsigned WIDTH    = 128,
    parameter int unsigned NUM_KEYS = 4,
    parameter int unsigned LANE     = 32
) (
    input  logic             pclk,
    input  logic             preset_n,
    input  logic [31:0]      paddr,
    input  logic             psel,
    input  logic             penable,
    input  logic             pwrite,
    input  logic [2:0]       pprot,
    input  logic [WIDTH-1:0] pwdata,
    output logic [WIDTH-1:0] prdata,
    output logic             pready,
    output logic             pslverr,
    output logic             busy
);

    localparam int unsigned NLanes = WIDTH / LANE;
    localparam int unsigned LaneW  = (NLanes > 1) ? $clog2(NLanes) : 1;

    otp_state_e                     state_q, state_d;
    logic [LaneW-1:0]               lane_q, lane_d;
    logic [WIDTH-1:0]               data_q, data_d, result_q, result_d;
    logic [CtrlSelW-1:0]            run_sel_q, run_sel_d, sel_q, sel_d;
    logic                           lock_q, lock_d;
    logic [NUM_KEYS-1:0][WIDTH-1:0] keys;
    logic [NUM_KEYS-1:0]            valid;
    logic [WIDTH-1:0]               run_key, rd_data;
    logic                           sel_valid, acc, err;
    logic                           key_we, data_we, ctrl_we, res_rd, done_clr, sweep_start;
    logic                           sweep_last;
    logic                           unused_prot;

    assign unused_prot = pprot[2];
    assign acc         = psel & penable & preset_n;

    always_comb begin
        run_key   = '0;
        sel_valid = 1'b0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (run_sel_q == CtrlSelW'(i)) run_key = keys[i];
            if (sel_q == CtrlSelW'(i)) sel_valid = valid[i];
        end
    end

    // Access decode: rd_data is only populated for accepted reads.
    always_comb begin
        err     = 1'b0;
        key_we  = 1'b0;
        data_we = 1'b0;
        ctrl_we = 1'b0;
        res_rd  = 1'b0;
        rd_data = '0;
        if (acc) begin
            if (state_q == StZero) begin
                err = 1'b1;
            end else if (paddr < 32'(NUM_KEYS)) begin
                if (pwrite && pprot[0] && !pprot[1] && !lock_q) key_we = 1'b1;
                else err = 1'b1;
            end else begin
                case (paddr)
                    AddrData: begin
                        if (pwrite && state_q == StIdle && sel_valid) data_we = 1'b1;
                        else err = 1'b1;
                    end
                    AddrCtrl: begin
                        if (!pwrite) begin
                            rd_data[CtrlSelLsb +: CtrlSelW] = sel_q;
                            rd_data[CtrlLockBit]            = lock_q;
                        end else if (32'(pwdata[CtrlSelLsb +: CtrlSelW]) >= 32'(NUM_KEYS)) begin
                            err = 1'b1;
                        end else begin
                            ctrl_we = 1'b1;
                        end
                    end
                    AddrStatus: begin
                        if (pwrite) begin
                            err = 1'b1;
                        end else begin
                            rd_data[1:0]                         = state_q;
                            rd_data[StatDoneBit]                 = (state_q == StDone);
                            rd_data[StatValidLsb +: NUM_KEYS]    = valid;
                        end
                    end
                    AddrResult: begin
                        if (!pwrite && state_q == StDone && !pprot[1]) begin
                            res_rd  = 1'b1;
                            rd_data = result_q;
                        end else begin
                            err = 1'b1;
                        end
                    end
                    default: err = 1'b1;
                endcase
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        data_d      = data_q;
        result_d    = result_q;
        run_sel_d   = run_sel_q;
        sel_d       = sel_q;
        lock_d      = lock_q;
        done_clr    = 1'b0;
        sweep_start = 1'b0;
        if (ctrl_we) begin
            sel_d  = pwdata[CtrlSelLsb +: CtrlSelW];
            lock_d = lock_q | pwdata[CtrlLockBit];
        end
        unique case (state_q)
            StIdle: begin
                if (data_we) begin
                    data_d    = pwdata;
                    run_sel_d = sel_q;
                    result_d  = '0;
                    lane_d    = '0;
                    state_d   = StBusy;
                end
            end
            StBusy: begin
                for (int l = 0; l < NLanes; l++) begin
                    if (lane_q == LaneW'(l)) begin
                        result_d[l*LANE +: LANE] = data_q[l*LANE +: LANE] ^ run_key[l*LANE +: LANE];
                    end
                end
                if (lane_q == LaneW'(NLanes - 1)) begin
                    lane_d   = '0;
                    state_d  = StDone;
                    done_clr = 1'b1;
                end else begin
                    lane_d = lane_q + LaneW'(1);
                end
            end
            StDone: begin
                if (res_rd) begin
                    result_d = '0;
                    data_d   = '0;
                    state_d  = StIdle;
                end
            end
            StZero: begin
                if (sweep_last) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Zeroize aborts any run; the sweep clears the in-use slot as well.
        if (ctrl_we && pwdata[CtrlZeroBit]) begin
            state_d     = StZero;
            data_d      = '0;
            result_d    = '0;
            lane_d      = '0;
            done_clr    = 1'b0;
            sweep_start = 1'b1;
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q   <= StIdle;
            lane_q    <= '0;
            data_q    <= '0;
            result_q  <= '0;
            run_sel_q <= '0;
            sel_q     <= '0;
            lock_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lane_q    <= lane_d;
            data_q    <= data_d;
            result_q  <= result_d;
            run_sel_q <= run_sel_d;
            sel_q     <= sel_d;
            lock_q    <= lock_d;
        end
    end

    otp_key_bank #(
        .WIDTH    (WIDTH),
        .NUM_KEYS (NUM_KEYS)
    ) u_key_bank (
        .clk_i         (pclk),
        .rst_ni        (preset_n),
        .we_i          (key_we),
        .widx_i        (paddr[CtrlSelW-1:0]),
        .wdata_i       (pwdata),
        .clr_i         (done_clr),
        .clr_idx_i     (run_sel_q),
        .sweep_start_i (sweep_start),
        .sweep_i       (state_q == StZero),
        .sweep_last_o  (sweep_last),
        .keys_o        (keys),
        .valid_o       (valid)
    );

    assign pready = psel & penable;
    assign prdata = rd_data;
    assign busy   = (state_q == StBusy) || (state_q == StZero);
`ifdef APB_OTP_PSLVERR_EN
    assign pslverr = err;
`else
    assign pslverr = 1'b0;
`endif

endmodule

// File: tb/tb_apb_otp_keystore.sv
// Randomized APB bench for apb_otp_keystore against a cycle-level behavioural model,
// plus directed scenarios with literal expectations.
module tb_apb_otp_keystore;

    localparam int W  = 128;
    localparam int NK = 4;
    localparam int LN = 32;
    localparam int NL = W / LN;
`ifdef APB_OTP_PSLVERR_EN
    localparam bit PSLV = 1'b1;
`else
    localparam bit PSLV = 1'b0;
`endif

    localparam int KNone = 0, KKey = 1, KData = 2, KCtrlW = 3, KCtrlR = 4, KStat = 5, KRes = 6;

    logic          pclk = 1'b0;
    logic          preset_n = 1'b0;
    logic [31:0]   paddr = '0;
    logic          psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [2:0]    pprot = '0;
    logic [W-1:0]  pwdata = '0;
    logic [W-1:0]  prdata;
    logic          pready, pslverr, busy;

    int total = 0;
    int bad = 0;

    // Behavioural model state; m_state uses the STATUS[1:0] numbering
    logic [W-1:0] m_key[16];
    bit           m_valid[16];
    logic [W-1:0] m_data, m_result;
    int           m_state, m_lane, m_rsel, m_sel, m_zcnt;
    bit           m_lock;

    apb_otp_keystore #(
        .WIDTH    (W),
        .NUM_KEYS (NK),
        .LANE     (LN)
    ) dut (
        .pclk     (pclk),
        .preset_n (preset_n),
        .paddr    (paddr),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .pprot    (pprot),
        .pwdata   (pwdata),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr),
        .busy     (busy)
    );

    initial forever #5 pclk = ~pclk;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void mreset();
        for (int i = 0; i < 16; i++) begin
            m_key[i]   = '0;
            m_valid[i] = 1'b0;
        end
        m_data = '0; m_result = '0;
        m_state = 0; m_lane = 0; m_rsel = 0; m_sel = 0; m_zcnt = 0; m_lock = 1'b0;
    endfunction

    function automatic logic [W-1:0] mstatus();
        logic [W-1:0] s = '0;
        for (int i = 0; i < NK; i++) s[16+i] = m_valid[i];
        s[1:0] = 2'(m_state);
        s[2]   = (m_state == 2);
        return s;
    endfunction

    // What the current bus access means under the model's present state
    function automatic void classify(output int kind, output bit err, output logic [W-1:0] rd);
        kind = KNone; err = 1'b0; rd = '0;
        if (!(psel && penable) || !preset_n) return;
        if (m_state == 3) begin
            err = 1'b1;
            return;
        end
        if (paddr < NK) begin
            if (pwrite && pprot[0] && !pprot[1] && !m_lock) kind = KKey;
            else err = 1'b1;
            return;
        end
        case (paddr)
            32'h10: if (pwrite && m_state == 0 && m_valid[m_sel]) kind = KData; else err = 1'b1;
            32'h11: begin
                if (!pwrite) begin
                    kind = KCtrlR;
                    rd = W'(m_sel);
                    rd[4] = m_lock;
                end else if (int'(pwdata[3:0]) < NK) kind = KCtrlW;
                else err = 1'b1;
            end
            32'h12: if (pwrite) err = 1'b1; else begin kind = KStat; rd = mstatus(); end
            32'h13: begin
                if (!pwrite && m_state == 2 && !pprot[1]) begin
                    kind = KRes;
                    rd = m_result;
                end else err = 1'b1;
            end
            default: err = 1'b1;
        endcase
    endfunction

    function automatic void mstep();
        int k; bit e; logic [W-1:0] r; bit done_enter;
        classify(k, e, r);
        done_enter = 1'b0;
        if (m_state == 1) begin
            m_result[m_lane*LN +: LN] = m_data[m_lane*LN +: LN] ^ m_key[m_rsel][m_lane*LN +: LN];
            m_lane++;
            if (m_lane == NL) begin
                m_lane = 0; m_state = 2; done_enter = 1'b1;
            end
        end else if (m_state == 3) begin
            m_key[m_zcnt] = '0; m_valid[m_zcnt] = 1'b0;
            m_zcnt++;
            if (m_zcnt == NK) m_state = 0;
        end
        case (k)
            KKey: begin m_key[paddr] = pwdata; m_valid[paddr] = 1'b1; end
            KData: begin
                m_data = pwdata; m_rsel = m_sel; m_result = '0; m_lane = 0; m_state = 1;
            end
            KCtrlW: begin
                m_sel = int'(pwdata[3:0]);
                m_lock = m_lock | pwdata[4];
                if (pwdata[5]) begin
                    m_state = 3; m_zcnt = 0; m_data = '0; m_result = '0; m_lane = 0;
                end
            end
            KRes: begin m_result = '0; m_data = '0; m_state = 0; end
            default: ;
        endcase
        if (done_enter) begin
            m_key[m_rsel] = '0; m_valid[m_rsel] = 1'b0;
        end
    endfunction

    initial begin
        mreset();
        forever begin
            @(posedge pclk or negedge preset_n);
            if (!preset_n) mreset();
            else mstep();
        end
    end

    initial begin
        int k; bit e; logic [W-1:0] r;
        forever begin
            @(negedge pclk);
            classify(k, e, r);
            chk("pready", W'(pready), W'(psel && penable));
            chk("pslverr", W'(pslverr), W'(PSLV && e));
            chk("prdata", prdata, e ? '0 : r);
            chk("busy", W'(busy), W'(m_state == 1 || m_state == 3));
        end
    end

    // Starts and ends just after a rising edge
    task automatic apb(input logic [31:0] a, input bit wr, input logic [2:0] prot,
                       input logic [W-1:0] wd, output logic [W-1:0] rd, output bit er);
        paddr = a; pwrite = wr; pprot = prot; pwdata = wd; psel = 1'b1; penable = 1'b0;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk);
        rd = prdata; er = pslverr;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic do_reset();
        preset_n = 1'b0;
        @(posedge pclk); @(posedge pclk); #1;
        preset_n = 1'b1;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        repeat (10) begin
            @(negedge pclk);
            if (busy) n++;
        end
        @(posedge pclk); #1;
    endtask

    initial begin
        logic [W-1:0] rd, wd;
        bit er;
        int n, rsel;
        logic [2:0] prot;
        logic [31:0] oddaddr[6];
        oddaddr = '{32'h14, 32'h4, 32'h10, 32'h12, 32'h13, 32'hFFFF_FFFF};

        @(posedge pclk); #1;
        do_reset();
        chk("reset_busy", W'(busy), '0);
        apb(32'h12, 1'b0, 3'b000, '0, rd, er);
        chk("reset_status", rd, '0);
        chk("reset_status_err", W'(er), '0);

        // Non-secure privileged key write is rejected
        apb(32'h0, 1'b1, 3'b011, {4{32'h1234_5678}}, rd, er);
        chk("key0_prot_err", W'(er), W'(PSLV));
        apb(32'h12, 1'b0, 3'b000, '0, rd, er);
        chk("key0_not_valid", rd, '0);

        // Basic single-use encryption
        apb(32'h1, 1'b1, 3'b001, {4{32'hA5A5_A5A5}}, rd, er);
        chk("key1_write_err", W'(er), '0);
        apb(32'h11, 1'b1, 3'b000, W'(1), rd, er);
        apb(32'h10, 1'b1, 3'b000, {W{1'b1}}, rd, er);
        chk("data_write_err", W'(er), '0);
        count_busy(n);
        chk("busy_cycles", W'(n), W'(4));
        apb(32'h12, 1'b0, 3'b000, '0, rd, er);
        chk("status_done", rd, W'(6));
        apb(32'h13, 1'b0, 3'b000, '0, rd, er);
        chk("result", rd, {4{32'h5A5A_5A5A}});
        chk("result_err", W'(er), '0);
        apb(32'h12, 1'b0, 3'b000, '0, rd, er);
        chk("status_after_result", rd, '0);

        // Key already consumed
        apb(32'h10, 1'b1, 3'b000, {W{1'b1}}, rd, er);
        chk("reuse_err", W'(er), W'(PSLV));
        apb(32'h12, 1'b0, 3'b000, '0, rd, er);
        chk("reuse_idle", rd, '0);

        // Zeroize while a run is in flight
        apb(32'h0, 1'b1, 3'b001, {4{32'h0F0F_0F0F}}, rd, er);
        apb(32'h3, 1'b1, 3'b001, {4{32'h3333_3333}}, rd, er);
        apb(32'h11, 1'b1, 3'b000, W'(0), rd, er);
        apb(32'h10, 1'b1, 3'b000, {4{32'hDEAD_BEEF}}, rd, er);
        apb(32'h11, 1'b1, 3'b000, W'(32'h20), rd, er);
        count_busy(n);
        chk("zero_cycles", W'(n), W'(4));
        apb(32'h12, 1'b0, 3'b000, '0, rd, er);
        chk("zero_status", rd, '0);
        apb(32'h13, 1'b0, 3'b000, '0, rd, er);
        chk("zero_result_err", W'(er), W'(PSLV));
        chk("zero_result_data", rd, '0);

        // Lock holds until reset
        apb(32'h11, 1'b1, 3'b000, W'(32'h10), rd, er);
        apb(32'h2, 1'b1, 3'b001, {4{32'h7777_7777}}, rd, er);
        chk("locked_key_err", W'(er), W'(PSLV));
        apb(32'h11, 1'b0, 3'b000, '0, rd, er);
        chk("ctrl_lock", rd, W'(32'h10));
        do_reset();
        apb(32'h2, 1'b1, 3'b001, {4{32'h7777_7777}}, rd, er);
        chk("unlocked_key_err", W'(er), '0);
        apb(32'h12, 1'b0, 3'b000, '0, rd, er);
        chk("key2_valid", rd, W'(32'h0004_0000));

        // Asynchronous reset mid-run
        apb(32'h11, 1'b1, 3'b000, W'(2), rd, er);
        apb(32'h10, 1'b1, 3'b000, {4{32'hCAFE_F00D}}, rd, er);
        @(posedge pclk); #3;
        preset_n = 1'b0;
        #1;
        chk("async_busy", W'(busy), '0);
        chk("async_prdata", prdata, '0);
        @(posedge pclk); #1;
        preset_n = 1'b1;
        apb(32'h12, 1'b0, 3'b000, '0, rd, er);
        chk("async_status", rd, '0);

        for (int it = 0; it < 1500; it++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge pclk); #1; end
            wd = {$urandom, $urandom, $urandom, $urandom};
            case ($urandom_range(0, 3))
                0: prot = 3'b001;
                1: prot = 3'b011;
                2: prot = 3'b000;
                default: prot = 3'b101;
            endcase
            n = $urandom_range(0, 99);
            if (n < 18) apb(32'($urandom_range(0, NK)), 1'b1, prot, wd, rd, er);
            else if (n < 32) begin
                rsel = $urandom_range(0, 5);
                wd[3:0] = 4'(rsel);
                wd[4] = ($urandom_range(0, 49) == 0);
                wd[5] = ($urandom_range(0, 11) == 0);
                apb(32'h11, 1'b1, 3'b000, wd, rd, er);
            end
            else if (n < 46) apb(32'h10, 1'b1, 3'b000, wd, rd, er);
            else if (n < 64) apb(32'h13, 1'b0, ($urandom_range(0, 3) == 0) ? 3'b010 : 3'b000,
                                 wd, rd, er);
            else if (n < 78) apb(32'h12, 1'b0, 3'b000, wd, rd, er);
            else if (n < 84) apb(32'h11, 1'b0, 3'b000, wd, rd, er);
            else if (n < 97) apb(oddaddr[$urandom_range(0, 5)], 1'($urandom_range(0, 1)),
                                 prot, wd, rd, er);
            else do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
